// File: rtl/core_pkg.sv
// Shared core types for the writeback path.
//   XLEN / NREGS : datapath width and architectural register count
//   reg_idx_t    : register index
//   xlen_t       : one datapath word
//   wb_req_t     : one writeback request {valid, destination, data}
package core_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    typedef logic [4:0]      reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        logic     v;
        reg_idx_t rd;
        xlen_t    data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/quantum unit/decode and the writeback arbiter.
//   alu_*        : pipeline writeback (no backpressure)
//   qi_*         : quantum measure issue (marks rd pending)
//   qm_*         : measurement result handshake (qm_ready = FIFO not full)
//   dec_*        : decode operand indices, hazard_stall back to decode
//   we/rd/wd     : register file write port
//   qfifo_count  : result FIFO occupancy (debug)
// Modports: slave = arbiter side, master = surrounding core side.
interface wb_arbiter_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned QFIFO_DEPTH = 4
);
    import core_pkg::*;

    localparam int unsigned CW = $clog2(QFIFO_DEPTH) + 1;

    logic            alu_valid;
    reg_idx_t        alu_rd;
    logic [XLEN-1:0] alu_wd;
    logic            qi_valid;
    reg_idx_t        qi_rd;
    logic            qm_valid;
    logic            qm_ready;
    reg_idx_t        qm_rd;
    logic [XLEN-1:0] qm_data;
    reg_idx_t        dec_rs1;
    reg_idx_t        dec_rs2;
    reg_idx_t        dec_rd;
    logic            hazard_stall;
    logic            we;
    reg_idx_t        rd;
    logic [XLEN-1:0] wd;
    logic [CW-1:0]   qfifo_count;

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        input  qi_valid, qi_rd,
        input  qm_valid, qm_rd, qm_data,
        input  dec_rs1, dec_rs2, dec_rd,
        output qm_ready, hazard_stall,
        output we, rd, wd, qfifo_count
    );

    modport master (
        output alu_valid, alu_rd, alu_wd,
        output qi_valid, qi_rd,
        output qm_valid, qm_rd, qm_data,
        output dec_rs1, dec_rs2, dec_rd,
        input  qm_ready, hazard_stall,
        input  we, rd, wd, qfifo_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH a power of two (pointers wrap naturally).
//   push_i/wdata_i : write when not full (push while full is ignored)
//   pop_i/rdata_o  : rdata_o shows the head; pop when empty is ignored
//   full_o/empty_o : status from registered count only (no pop-through)
//   count_o        : occupancy 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter and pending-register scoreboard.
// Drives the register file's single write port from two sources:
//   - pipeline ALU/load results (never stalled, highest priority)
//   - quantum measurement results, buffered in a sync_fifo
// Tracks destinations of in-flight measurements and stalls decode on
// RAW/WAW hazards against them.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_arbiter_if slave modport (see interface header)
module wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned XLEN        = core_pkg::XLEN,
    parameter int unsigned NREGS       = core_pkg::NREGS,
    parameter int unsigned QFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    wb_arbiter_if.slave bus
);

    localparam int unsigned CW = $clog2(QFIFO_DEPTH) + 1;
    localparam int unsigned EW = 5 + XLEN;

    logic [EW-1:0]    fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]    fifo_count;
    reg_idx_t         head_rd;
    logic [XLEN-1:0]  head_data;
    logic             alu_sel;

    logic             we_q, we_d;
    reg_idx_t         rd_q, rd_d;
    logic [XLEN-1:0]  wd_q, wd_d;
    logic [NREGS-1:0] pending_q, pending_d;

    assign fifo_wdata = {bus.qm_rd, bus.qm_data};
    assign head_rd    = fifo_rdata[EW-1 -: 5];
    assign head_data  = fifo_rdata[XLEN-1:0];

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (QFIFO_DEPTH)
    ) u_qfifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.qm_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A write to x0 from the ALU is treated as idle so the FIFO can drain.
    assign alu_sel  = bus.alu_valid && (bus.alu_rd != '0);
    assign fifo_pop = !alu_sel && !fifo_empty;

    always_comb begin
        we_d      = 1'b0;
        rd_d      = rd_q;
        wd_d      = wd_q;
        pending_d = pending_q;
        if (alu_sel) begin
            we_d = 1'b1;
            rd_d = bus.alu_rd;
            wd_d = bus.alu_wd;
        end else if (fifo_pop) begin
            // x0 results are consumed silently.
            if (head_rd != '0) begin
                we_d = 1'b1;
                rd_d = head_rd;
                wd_d = head_data;
            end
            pending_d[head_rd] = 1'b0;
        end
        // Applied after the clear so a same-edge reissue keeps the bit set.
        if (bus.qi_valid && (bus.qi_rd != '0)) pending_d[bus.qi_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q      <= 1'b0;
            rd_q      <= '0;
            wd_q      <= '0;
            pending_q <= '0;
        end else begin
            we_q      <= we_d;
            rd_q      <= rd_d;
            wd_q      <= wd_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        bus.hazard_stall = ((bus.dec_rs1 != '0) && pending_q[bus.dec_rs1]) ||
                           ((bus.dec_rs2 != '0) && pending_q[bus.dec_rs2]) ||
                           ((bus.dec_rd  != '0) && pending_q[bus.dec_rd]);
    end

    assign bus.qm_ready    = !fifo_full;
    assign bus.qfifo_count = fifo_count;
    assign bus.we          = we_q;
    assign bus.rd          = rd_q;
    assign bus.wd          = wd_q;

endmodule
